toe_conn_requester: RTL and testbench
=====================================

# toe_conn_requester

Host-side initiator for the TOE connection-table request interface. It accepts one connection command from the host (open, lookup or close, plus the connection 4-tuple and MACs) and drives the TOE request port with a four-phase handshake. It waits for a nonzero reply and returns it to the host. A cycle timeout guards against a responder that never answers. It sits between the host register/command path and the TOE init/search engine.

## Interface
- TIMEOUT_CYCLES, 1024: maximum cycles to wait for a nonzero reply, and separately for the reply to return to zero.
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- cmd_valid  in  1  host command present
- cmd_ready  out  1  command accepted this cycle when both cmd_valid and cmd_ready are high
- cmd_code  in  2  01 open, 10 lookup, 11 close, 00 invalid
- cmd_id  in  8  connection id
- cmd_ip_src, cmd_ip_dst  in  32 each  IPv4 addresses
- cmd_mac_src, cmd_mac_dst  in  48 each  MAC addresses
- cmd_port_src, cmd_port_dst  in  16 each  TCP ports
- rsp_valid  out  1  response available
- rsp_ready  in  1  host consumes response
- rsp_reply  out  8  captured reply or local status code
- rsp_timeout  out  1  response generated by timeout
- req_code  out  2  request code to TOE; 00 means no request
- id_in  out  8  id to TOE
- ip_src, ip_dst  out  32 each  tuple to TOE
- mac_src, mac_dst  out  48 each  tuple to TOE
- port_src, port_dst  out  16 each  tuple to TOE
- reply  in  8  TOE reply; 00 means none

## Operation
- States: IDLE, ISSUE, RELEASE, RESPOND.
- IDLE:
  - cmd_ready is 1, except 0 while rst is high.
  - On acceptance with code 01–11, register code, id and tuple, then go to ISSUE.
  - On acceptance with code 00, load rsp_reply=8'hFE and rsp_timeout=0, then go to RESPOND. No TOE activity occurs.
  - A nonzero reply seen in IDLE is ignored.
- ISSUE:
  - req_code holds the registered code; the tuple outputs are held stable.
  - When reply!=0: capture reply into rsp_reply, clear the counter, go to RELEASE.
  - When the counter reaches TIMEOUT_CYCLES-1 with reply==0: set rsp_reply=8'hFF and rsp_timeout=1, go to RELEASE.
- RELEASE:
  - req_code=00; the tuple outputs are still held.
  - When reply==0, go to RESPOND.
  - If reply stays nonzero for TIMEOUT_CYCLES cycles: set rsp_timeout=1 while keeping the captured rsp_reply, then go to RESPOND.
- RESPOND:
  - rsp_valid=1; rsp_reply and rsp_timeout are stable.
  - On rsp_ready, go to IDLE.
- Counter:
  - $clog2(TIMEOUT_CYCLES)-bit width, saturating.
  - Cleared on every state entry.
- Reset, in any state including mid-handshake: state IDLE, req_code=00, and all TOE tuple outputs, rsp_reply, rsp_timeout, rsp_valid and the counter are 0. Outstanding commands are dropped.

## Timing
- Command accepted at edge N: req_code is nonzero from cycle N+1.
- reply!=0 sampled at edge M: req_code=00 from M+1.
- reply==0 sampled at edge K in RELEASE: rsp_valid=1 from K+1.
- Minimum command-to-response latency is 3 cycles, for a responder that replies and releases within one cycle each.
- The invalid-code path gives rsp_valid 1 cycle after acceptance.
- rsp_valid && rsp_ready at edge R: cmd_ready=1 from R+1. Back-to-back commands are therefore separated by at least one IDLE cycle.
- All outputs are registered except cmd_ready, which is decoded from the state and gated by rst.

## Structure
- Package toe_pkg holds:
  - the request-code enum (REQ_NONE=2'b00, REQ_OPEN=2'b01, REQ_LOOKUP=2'b10, REQ_CLOSE=2'b11);
  - the reply constants REPLY_NONE=8'h00, REPLY_BADCMD=8'hFE and REPLY_TIMEOUT=8'hFF;
  - a packed struct conn_tuple_t containing ip, mac and port fields.
- The register-stage state enum is local.
- One sub-module, toe_timeout_ctr (a parameterised saturating counter with clear and a terminal-count output), is natural.
- Everything else is flat.

## Test plan
- Lookup with id=8'h05, ip_src=32'h0A000001, port_dst=16'd80; responder drives reply=8'h01 three cycles after req, then 0 one cycle after req drops. Required: req_code=10 with a stable tuple throughout; rsp_reply=8'h01, rsp_timeout=0; rsp_valid held until rsp_ready.
- cmd_code=00. Required: req_code stays 00 throughout; rsp_reply=8'hFE one cycle after acceptance.
- TIMEOUT_CYCLES=16 and the responder is silent. Required: req_code=01 for exactly 16 cycles, then 00; rsp_reply=8'hFF, rsp_timeout=1.
- Responder holds reply=8'h02 for 16 cycles after req drops, with TIMEOUT_CYCLES=16. Required: rsp_reply=8'h02, rsp_timeout=1.
- rst pulsed during ISSUE. Required: the next cycle shows req_code=00, rsp_valid=0 and all tuple outputs 0; a new command then completes normally.
- Stale reply=8'h03 while IDLE, then a close command is issued. Required: the stale value is not captured before ISSUE. With the reply still nonzero on the first ISSUE cycle, it is captured as 8'h03 (this documents the intended behaviour).

Source files
------------

// File: rtl/toe_pkg.sv
// Shared types and constants for the TOE connection-table request interface.
package toe_pkg;

  typedef enum logic [1:0] {
    REQ_NONE   = 2'b00,
    REQ_OPEN   = 2'b01,
    REQ_LOOKUP = 2'b10,
    REQ_CLOSE  = 2'b11
  } req_code_e;

  localparam logic [7:0] REPLY_NONE    = 8'h00;
  localparam logic [7:0] REPLY_BADCMD  = 8'hFE;
  localparam logic [7:0] REPLY_TIMEOUT = 8'hFF;

  typedef struct packed {
    logic [31:0] ip_src;
    logic [31:0] ip_dst;
    logic [47:0] mac_src;
    logic [47:0] mac_dst;
    logic [15:0] port_src;
    logic [15:0] port_dst;
  } conn_tuple_t;

endpackage

// File: rtl/toe_timeout_ctr.sv
// Saturating cycle counter with synchronous clear; tc flags the last count.
module toe_timeout_ctr #(
  parameter int unsigned TERMINAL = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tc
);

  localparam int unsigned W = (TERMINAL > 1) ? $clog2(TERMINAL) : 1;
  localparam logic [W-1:0] LAST = W'(TERMINAL - 1);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (cnt_q != LAST) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc = (cnt_q == LAST);

endmodule

// File: rtl/toe_conn_requester.sv
// Host-side initiator: issues one connection command to the TOE with a
// four-phase req/reply handshake and returns the reply (or a status code).
module toe_conn_requester
  import toe_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_code,
  input  logic [7:0]  cmd_id,
  input  logic [31:0] cmd_ip_src,
  input  logic [31:0] cmd_ip_dst,
  input  logic [47:0] cmd_mac_src,
  input  logic [47:0] cmd_mac_dst,
  input  logic [15:0] cmd_port_src,
  input  logic [15:0] cmd_port_dst,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [7:0]  rsp_reply,
  output logic        rsp_timeout,
  output logic [1:0]  req_code,
  output logic [7:0]  id_in,
  output logic [31:0] ip_src,
  output logic [31:0] ip_dst,
  output logic [47:0] mac_src,
  output logic [47:0] mac_dst,
  output logic [15:0] port_src,
  output logic [15:0] port_dst,
  input  logic [7:0]  reply
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_RELEASE,
    ST_RESPOND
  } state_e;

  state_e      state_q, state_d;
  req_code_e   req_q, req_d;
  logic [7:0]  id_q, id_d;
  conn_tuple_t tuple_q, tuple_d;
  logic [7:0]  rsp_reply_q, rsp_reply_d;
  logic        rsp_timeout_q, rsp_timeout_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic        ctr_clr, ctr_tc;
  logic        reply_seen;

  assign reply_seen = (reply != REPLY_NONE);
  assign cmd_ready  = (state_q == ST_IDLE) && !rst;

  // Counter restarts whenever the FSM changes state, so each wait phase
  // gets its own full TIMEOUT_CYCLES budget.
  assign ctr_clr = (state_d != state_q);

  toe_timeout_ctr #(
    .TERMINAL(TIMEOUT_CYCLES)
  ) u_ctr (
    .clk(clk),
    .rst(rst),
    .clr(ctr_clr),
    .tc (ctr_tc)
  );

  always_comb begin
    state_d       = state_q;
    req_d         = req_q;
    id_d          = id_q;
    tuple_d       = tuple_q;
    rsp_reply_d   = rsp_reply_q;
    rsp_timeout_d = rsp_timeout_q;

    unique case (state_q)
      ST_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          if (cmd_code != REQ_NONE) begin
            req_d            = req_code_e'(cmd_code);
            id_d             = cmd_id;
            tuple_d.ip_src   = cmd_ip_src;
            tuple_d.ip_dst   = cmd_ip_dst;
            tuple_d.mac_src  = cmd_mac_src;
            tuple_d.mac_dst  = cmd_mac_dst;
            tuple_d.port_src = cmd_port_src;
            tuple_d.port_dst = cmd_port_dst;
            rsp_reply_d      = REPLY_NONE;
            rsp_timeout_d    = 1'b0;
            state_d          = ST_ISSUE;
          end else begin
            rsp_reply_d   = REPLY_BADCMD;
            rsp_timeout_d = 1'b0;
            state_d       = ST_RESPOND;
          end
        end
      end
      ST_ISSUE: begin
        if (reply_seen) begin
          rsp_reply_d = reply;
          req_d       = REQ_NONE;
          state_d     = ST_RELEASE;
        end else if (ctr_tc) begin
          rsp_reply_d   = REPLY_TIMEOUT;
          rsp_timeout_d = 1'b1;
          req_d         = REQ_NONE;
          state_d       = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        if (!reply_seen) begin
          state_d = ST_RESPOND;
        end else if (ctr_tc) begin
          rsp_timeout_d = 1'b1;
          state_d       = ST_RESPOND;
        end
      end
      ST_RESPOND: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    rsp_valid_d = (state_d == ST_RESPOND);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      req_q         <= REQ_NONE;
      id_q          <= '0;
      tuple_q       <= '0;
      rsp_reply_q   <= '0;
      rsp_timeout_q <= 1'b0;
      rsp_valid_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      req_q         <= req_d;
      id_q          <= id_d;
      tuple_q       <= tuple_d;
      rsp_reply_q   <= rsp_reply_d;
      rsp_timeout_q <= rsp_timeout_d;
      rsp_valid_q   <= rsp_valid_d;
    end
  end

  assign req_code    = req_q;
  assign id_in       = id_q;
  assign ip_src      = tuple_q.ip_src;
  assign ip_dst      = tuple_q.ip_dst;
  assign mac_src     = tuple_q.mac_src;
  assign mac_dst     = tuple_q.mac_dst;
  assign port_src    = tuple_q.port_src;
  assign port_dst    = tuple_q.port_dst;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_reply   = rsp_reply_q;
  assign rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_toe_conn_requester.sv
// Scoreboard bench for toe_conn_requester with TIMEOUT_CYCLES=16.
module tb_toe_conn_requester;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready;
  logic [1:0]  cmd_code;
  logic [7:0]  cmd_id;
  logic [31:0] cmd_ip_src, cmd_ip_dst;
  logic [47:0] cmd_mac_src, cmd_mac_dst;
  logic [15:0] cmd_port_src, cmd_port_dst;
  logic        rsp_valid, rsp_ready;
  logic [7:0]  rsp_reply;
  logic        rsp_timeout;
  logic [1:0]  req_code;
  logic [7:0]  id_in;
  logic [31:0] ip_src, ip_dst;
  logic [47:0] mac_src, mac_dst;
  logic [15:0] port_src, port_dst;
  logic [7:0]  reply;

  toe_conn_requester #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_code(cmd_code), .cmd_id(cmd_id),
    .cmd_ip_src(cmd_ip_src), .cmd_ip_dst(cmd_ip_dst),
    .cmd_mac_src(cmd_mac_src), .cmd_mac_dst(cmd_mac_dst),
    .cmd_port_src(cmd_port_src), .cmd_port_dst(cmd_port_dst),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_reply(rsp_reply), .rsp_timeout(rsp_timeout),
    .req_code(req_code), .id_in(id_in),
    .ip_src(ip_src), .ip_dst(ip_dst), .mac_src(mac_src), .mac_dst(mac_dst),
    .port_src(port_src), .port_dst(port_dst),
    .reply(reply)
  );

  always #5 clk = ~clk;

  int unsigned n_chk = 0;
  int unsigned n_err = 0;

  typedef struct packed {
    logic [7:0] reply;
    logic       tmo;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;

  // expected tuple, recorded from the stimulus when a command is driven
  logic [7:0]  e_id;
  logic [31:0] e_ip_src, e_ip_dst;
  logic [47:0] e_mac_src;
  logic [15:0] e_port_dst;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic drive_cmd(input logic [1:0] code, input logic [7:0] id,
                           input logic [31:0] ips, input logic [15:0] pdst);
    cmd_valid    = 1'b1;
    cmd_code     = code;
    cmd_id       = id;
    cmd_ip_src   = ips;
    cmd_ip_dst   = ips + 32'd1;
    cmd_mac_src  = {16'h0200, ips};
    cmd_mac_dst  = {16'h0400, ~ips};
    cmd_port_src = 16'hC000;
    cmd_port_dst = pdst;
    e_id = id; e_ip_src = ips; e_ip_dst = ips + 32'd1;
    e_mac_src = {16'h0200, ips}; e_port_dst = pdst;
  endtask

  task automatic check_tuple(string tag);
    chk({tag, "_id"}, id_in, e_id);
    chk({tag, "_ip_src"}, ip_src, e_ip_src);
    chk({tag, "_ip_dst"}, ip_dst, e_ip_dst);
    chk({tag, "_mac_src"}, mac_src, e_mac_src);
    chk({tag, "_port_dst"}, port_dst, e_port_dst);
  endtask

  task automatic wait_idle(string name);
    bit ok = 1'b0;
    for (int i = 0; i < 64; i++) begin
      tick();
      if (!rsp_valid && cmd_ready) begin
        ok = 1'b1;
        break;
      end
    end
    chk(name, ok, 1);
  endtask

  // monitor: a handshake happens at the next posedge whenever valid&&ready here
  always @(negedge clk) begin
    #1;
    if (rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
      if (sb_q.size() == 0) begin
        chk("sb_unexpected_rsp", 1, 0);
      end else begin
        mon_e = sb_q.pop_front();
        chk("mon_rsp_reply", rsp_reply, mon_e.reply);
        chk("mon_rsp_timeout", rsp_timeout, mon_e.tmo);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b1; cmd_valid = 1'b0; cmd_code = '0; cmd_id = '0;
    cmd_ip_src = '0; cmd_ip_dst = '0; cmd_mac_src = '0; cmd_mac_dst = '0;
    cmd_port_src = '0; cmd_port_dst = '0; rsp_ready = 1'b1; reply = '0;
    repeat (3) tick();
    chk("rst_req_code", req_code, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_ip_src", ip_src, 0);
    rst = 1'b0;
    tick();
    chk("idle_cmd_ready", cmd_ready, 1);

    // 1: lookup, reply 01 after a few cycles, response held until rsp_ready
    rsp_ready = 1'b0;
    drive_cmd(2'b10, 8'h05, 32'h0A000001, 16'd80);
    sb_q.push_back('{reply: 8'h01, tmo: 1'b0});
    tick();
    cmd_valid = 1'b0;
    chk("t1_req_code", req_code, 2);
    check_tuple("t1");
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("t1_req_hold", req_code, 2);
      check_tuple("t1_hold");
    end
    reply = 8'h01;
    tick();
    chk("t1_req_drop", req_code, 0);
    check_tuple("t1_release");
    reply = 8'h00;
    tick();
    chk("t1_rsp_valid", rsp_valid, 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t1_rsp_valid_hold", rsp_valid, 1);
    end
    rsp_ready = 1'b1;
    tick();
    chk("t1_rsp_done", rsp_valid, 0);
    chk("t1_cmd_ready", cmd_ready, 1);

    // 2: invalid code answered locally one cycle after acceptance
    drive_cmd(2'b00, 8'h22, 32'hC0A80001, 16'd443);
    sb_q.push_back('{reply: 8'hFE, tmo: 1'b0});
    tick();
    cmd_valid = 1'b0;
    chk("t2_req_code", req_code, 0);
    chk("t2_rsp_valid", rsp_valid, 1);
    chk("t2_rsp_reply", rsp_reply, 8'hFE);
    tick();
    chk("t2_req_code_after", req_code, 0);
    chk("t2_cmd_ready", cmd_ready, 1);

    // 3: silent responder, req held exactly TIMEOUT_CYCLES cycles
    drive_cmd(2'b01, 8'h33, 32'h0A000003, 16'd22);
    sb_q.push_back('{reply: 8'hFF, tmo: 1'b1});
    n = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (i == 0) cmd_valid = 1'b0;
      if (req_code == 2'b01) n++;
      else if (n > 0) break;
    end
    chk("t3_req_cycles", n, 16);
    wait_idle("t3_idle");

    // 4: reply stuck nonzero for TIMEOUT_CYCLES cycles after req drops
    drive_cmd(2'b10, 8'h44, 32'h0A000004, 16'd25);
    sb_q.push_back('{reply: 8'h02, tmo: 1'b1});
    tick();
    cmd_valid = 1'b0;
    reply = 8'h02;
    tick();
    chk("t4_req_drop", req_code, 0);
    repeat (16) tick();
    reply = 8'h00;
    wait_idle("t4_idle");

    // 5: reset mid-handshake, then a normal command
    drive_cmd(2'b10, 8'h55, 32'h0A000005, 16'd8080);
    tick();
    cmd_valid = 1'b0;
    chk("t5_req_code", req_code, 2);
    rst = 1'b1;
    tick();
    chk("t5_rst_req_code", req_code, 0);
    chk("t5_rst_rsp_valid", rsp_valid, 0);
    chk("t5_rst_id", id_in, 0);
    chk("t5_rst_ip_src", ip_src, 0);
    chk("t5_rst_mac_src", mac_src, 0);
    chk("t5_rst_port_dst", port_dst, 0);
    rst = 1'b0;
    tick();
    chk("t5_cmd_ready", cmd_ready, 1);
    drive_cmd(2'b01, 8'h56, 32'h0A000006, 16'd21);
    sb_q.push_back('{reply: 8'h11, tmo: 1'b0});
    tick();
    cmd_valid = 1'b0;
    chk("t5_new_req", req_code, 1);
    reply = 8'h11;
    tick();
    chk("t5_new_drop", req_code, 0);
    reply = 8'h00;
    wait_idle("t5_idle");

    // 6: stale reply in IDLE is ignored; still present on first ISSUE cycle
    reply = 8'h03;
    repeat (3) begin
      tick();
      chk("t6_idle_rsp_valid", rsp_valid, 0);
      chk("t6_idle_req", req_code, 0);
    end
    drive_cmd(2'b11, 8'h66, 32'h0A000007, 16'd23);
    sb_q.push_back('{reply: 8'h03, tmo: 1'b0});
    tick();
    cmd_valid = 1'b0;
    chk("t6_req_code", req_code, 3);
    chk("t6_not_captured", rsp_reply, 0);
    tick();
    chk("t6_req_drop", req_code, 0);
    reply = 8'h00;
    wait_idle("t6_idle");

    tick();
    chk("sb_drained", sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
